pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 2 (legal 1..15): cycles between halt detection in MEM and assertion of halt_out.
REQ-002 The block SHALL have these ports:
- CLK  in  1  rising-edge clock
- nRST  in  1  reset, synchronous, active-low
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- exmem_dmemreq  in  1  load/store in MEM stage
- mem_halt  in  1  halt instruction in MEM stage
- branch_taken  in  1  branch/jump resolved taken in EX
- idex_dRENi  in  1  load in EX stage
- idex_rt  in  5  EX-stage load destination
- ifid_rs  in  5  ID-stage source register
- ifid_rt  in  5  ID-stage source register
- pc_en  out  1  PC update enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline latch enables (idex_en drives the ID/EX latch en)
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch bubble insert (the ID/EX one drives the ID/EX latch flush)
- halt_out  out  1  processor halted, sticky
- stall_cnt  out  32  stall-cycle count (see Configuration)

Function
REQ-003 FSM states SHALL be RUN, LUSTALL, DRAIN, HALT; all *_en/*_flush outputs combinational from state and inputs; halt_out and stall_cnt registered.
REQ-004 Defaults in RUN/LUSTALL: all *_en=1, all *_flush=0; overrides apply in priority order REQ-005..REQ-008 (highest first).
REQ-005 memstall = exmem_dmemreq & ~dhit: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1; state unchanged; lower-priority conditions ignored that cycle.
REQ-006 branch_taken (no memstall): ifid_flush=1, idex_flush=1, pc_en=1; a concurrent load-use match SHALL NOT stall and SHALL NOT enter LUSTALL.
REQ-007 Load-use, RUN only: idex_dRENi & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt) -> pc_en=0, ifid_en=0, idex_flush=1; next state LUSTALL.
REQ-008 ~ihit: pc_en=0, ifid_flush=1; EX/MEM/WB latches advance.
REQ-009 LUSTALL SHALL last exactly one cycle unless memstall holds, then remain until memstall clears; load-use detection disabled in LUSTALL; next state RUN.
REQ-010 mem_halt in RUN/LUSTALL without memstall: next state DRAIN, drain counter loaded with DRAIN_CYCLES-1; mem_halt under memstall SHALL wait for memstall to clear.
REQ-011 DRAIN: pc_en=0, ifid_flush=idex_flush=exmem_flush=1, memwb_en=1; branch_taken/load-use/ihit ignored; counter decrements per cycle; at counter==0 next state HALT.
REQ-012 HALT: all *_en=0, all *_flush=0; halt_out=1 from the first HALT cycle, held until reset; state HALT terminal.
REQ-013 Total latency mem_halt-accepted to halt_out=1 SHALL be exactly DRAIN_CYCLES+1 cycles... defined as: accepting edge enters DRAIN, DRAIN_CYCLES DRAIN cycles, halt_out=1 on next edge.

Reset
REQ-014 On rising CLK with nRST=0: state=RUN, drain counter=0, halt_out=0, stall_cnt=0.
REQ-015 While nRST=0 all *_en SHALL be 0 and all *_flush SHALL be 1, irrespective of state (reset mid-DRAIN or mid-HALT aborts to RUN).

Configuration
REQ-016 With PIPE_PERF_CNT_EN defined, stall_cnt SHALL increment by 1 each cycle in RUN/LUSTALL with pc_en=0, saturating at 32'hFFFFFFFF, frozen in DRAIN/HALT.
REQ-017 Without PIPE_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-018 Load-use: idex_dRENi=1, idex_rt=5, ifid_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 one cycle; next cycle LUSTALL, all en=1.
REQ-019 $zero filter: idex_dRENi=1, idex_rt=0, ifid_rt=0 -> no stall, pc_en=1.
REQ-020 Branch+load-use same cycle: branch_taken=1 with REQ-018 match -> ifid_flush=idex_flush=1, pc_en=1, next state RUN.
REQ-021 Memstall precedence: exmem_dmemreq=1, dhit=0 for 3 cycles with branch_taken=1 -> pc_en=0, memwb_flush=1 for 3 cycles; branch flush applied on dhit=1 cycle.
REQ-022 Halt: DRAIN_CYCLES=2, mem_halt=1 at cycle 0 -> DRAIN cycles 1-2, halt_out=1 from cycle 3; nRST=0 at cycle 5 -> halt_out=0, state RUN.
REQ-023 Counter (PIPE_PERF_CNT_EN): ihit=0 for 7 cycles -> stall_cnt=7; undefined -> stall_cnt=0.

Source files
------------

// File: rtl/pipeline_control.sv
// Hazard/stall/flush controller for a 5-stage pipeline with a halt drain sequence.
// Optional stall-cycle performance counter enabled by defining PIPE_PERF_CNT_EN.
module pipeline_control #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dmemreq,
  input  logic        mem_halt,
  input  logic        branch_taken,
  input  logic        idex_dRENi,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halt_out,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StLuStall, StDrain, StHalt} state_e;

  state_e     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       halt_q, halt_d;
  logic       memstall;
  logic       load_use;

  assign memstall = exmem_dmemreq & ~dhit;
  assign load_use = idex_dRENi & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      StRun, StLuStall: begin
        if (memstall) begin
          // Whole front end freezes; a bubble drains into WB. State holds.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          if (state_q == StLuStall) state_d = StRun;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_en      = 1'b1;
          end else if (load_use && (state_q == StRun)) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = StLuStall;
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
          if (mem_halt) begin
            state_d     = StDrain;
            drain_cnt_d = 4'(DRAIN_CYCLES - 1);
          end
        end
      end
      StDrain: begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        if (drain_cnt_q == 4'd0) begin
          state_d = StHalt;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      StHalt: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      default: state_d = StRun;
    endcase

    // Reset forces every latch into bubble insertion regardless of state.
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  assign halt_d   = halt_q | (state_d == StHalt);
  assign halt_out = halt_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= StRun;
      drain_cnt_q <= 4'd0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_q      <= halt_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == StRun) || (state_q == StLuStall)) && !pc_en &&
        (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control (DRAIN_CYCLES = 2).
module tb_pipeline_control;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, exmem_dmemreq, mem_halt, branch_taken, idex_dRENi;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out;
  logic [31:0] stall_cnt;
  logic [8:0]  outs;

  int ncmp  = 0;
  int nfail = 0;

  // Bit order: pc, ifid, idex, exmem, memwb enables, then ifid, idex, exmem, memwb flushes.
  localparam logic [8:0] Normal  = 9'b11111_0000;
  localparam logic [8:0] Rst     = 9'b00000_1111;
  localparam logic [8:0] LuStall = 9'b00111_0100;
  localparam logic [8:0] Branch  = 9'b11111_1100;
  localparam logic [8:0] MStall  = 9'b00001_0001;
  localparam logic [8:0] IMiss   = 9'b01111_1000;
  localparam logic [8:0] Drain   = 9'b01111_1110;
  localparam logic [8:0] Halted  = 9'b00000_0000;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

  pipeline_control #(.DRAIN_CYCLES(2)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dmemreq(exmem_dmemreq),
    .mem_halt(mem_halt), .branch_taken(branch_taken), .idex_dRENi(idex_dRENi),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .halt_out(halt_out), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; exmem_dmemreq = 1'b0; mem_halt = 1'b0;
    branch_taken = 1'b0; idex_dRENi = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
  endtask

  task automatic set_lu();
    idex_dRENi = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    #1;
    ncmp++;
    if (outs !== Rst) begin nfail++; $display("FAIL reset_outs got=%b exp=%b", outs, Rst); end
    step();
    ncmp++;
    if (halt_out !== 1'b0) begin nfail++; $display("FAIL reset_halt got=%b exp=0", halt_out); end
    ncmp++;
    if (stall_cnt !== 32'd0) begin nfail++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    nRST = 1'b1;
    #1;
    ncmp++;
    if (outs !== Normal) begin nfail++; $display("FAIL run_outs got=%b exp=%b", outs, Normal); end
  endtask

  task automatic test_load_use();
    set_lu();
    #1;
    ncmp++;
    if (outs !== LuStall) begin nfail++; $display("FAIL lu_stall got=%b exp=%b", outs, LuStall); end
    step();
    // Same match in LUSTALL must not stall again.
    ncmp++;
    if (outs !== Normal) begin nfail++; $display("FAIL lu_lustall got=%b exp=%b", outs, Normal); end
    step();
    ncmp++;
    if (outs !== LuStall) begin nfail++; $display("FAIL lu_back_run got=%b exp=%b", outs, LuStall); end
    idle();
    step();
    step();
  endtask

  task automatic test_zero_filter();
    idle();
    idex_dRENi = 1'b1; idex_rt = 5'd0; ifid_rt = 5'd0; ifid_rs = 5'd3;
    #1;
    ncmp++;
    if (outs !== Normal) begin nfail++; $display("FAIL zero_filter got=%b exp=%b", outs, Normal); end
    idle();
    ifid_rt = 5'd7; idex_rt = 5'd7; idex_dRENi = 1'b1;
    #1;
    ncmp++;
    if (outs !== LuStall) begin nfail++; $display("FAIL lu_rt_match got=%b exp=%b", outs, LuStall); end
    idle();
    step();
    step();
  endtask

  task automatic test_branch_load_use();
    set_lu();
    branch_taken = 1'b1;
    #1;
    ncmp++;
    if (outs !== Branch) begin nfail++; $display("FAIL br_lu got=%b exp=%b", outs, Branch); end
    step();
    branch_taken = 1'b0;
    #1;
    // Still in RUN, so the match now stalls.
    ncmp++;
    if (outs !== LuStall) begin nfail++; $display("FAIL br_lu_next got=%b exp=%b", outs, LuStall); end
    idle();
    step();
    step();
  endtask

  task automatic test_memstall();
    exmem_dmemreq = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      ncmp++;
      if (outs !== MStall) begin
        nfail++; $display("FAIL memstall_%0d got=%b exp=%b", i, outs, MStall);
      end
      step();
    end
    dhit = 1'b1;
    #1;
    ncmp++;
    if (outs !== Branch) begin nfail++; $display("FAIL memstall_rel got=%b exp=%b", outs, Branch); end
    idle();
    step();
    // Memstall inside LUSTALL keeps LUSTALL until it clears.
    set_lu();
    step();
    exmem_dmemreq = 1'b1; dhit = 1'b0;
    step();
    step();
    exmem_dmemreq = 1'b0; dhit = 1'b1;
    #1;
    ncmp++;
    if (outs !== Normal) begin nfail++; $display("FAIL lustall_hold got=%b exp=%b", outs, Normal); end
    step();
    ncmp++;
    if (outs !== LuStall) begin nfail++; $display("FAIL lustall_exit got=%b exp=%b", outs, LuStall); end
    idle();
    step();
    step();
  endtask

  task automatic test_ihit_counter();
    logic [31:0] exp_cnt;
    do_reset();
    ihit = 1'b0;
    #1;
    ncmp++;
    if (outs !== IMiss) begin nfail++; $display("FAIL imiss got=%b exp=%b", outs, IMiss); end
    for (int i = 0; i < 7; i++) step();
    ihit = 1'b1;
`ifdef PIPE_PERF_CNT_EN
    exp_cnt = 32'd7;
`else
    exp_cnt = 32'd0;
`endif
    ncmp++;
    if (stall_cnt !== exp_cnt) begin
      nfail++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    // Halt arriving during memstall waits for it to clear.
    mem_halt = 1'b1; exmem_dmemreq = 1'b1; dhit = 1'b0;
    step();
    #1;
    ncmp++;
    if (outs !== MStall) begin nfail++; $display("FAIL halt_wait got=%b exp=%b", outs, MStall); end
    dhit = 1'b1;
    #1;
    // Cycle 0: halt accepted.
    ncmp++;
    if (outs !== Normal) begin nfail++; $display("FAIL halt_c0 got=%b exp=%b", outs, Normal); end
    step();
    idle();
    branch_taken = 1'b1; ihit = 1'b0; set_lu();
    #1;
    ncmp++;
    if (outs !== Drain) begin nfail++; $display("FAIL drain_c1 got=%b exp=%b", outs, Drain); end
    step();
    ncmp++;
    if (outs !== Drain) begin nfail++; $display("FAIL drain_c2 got=%b exp=%b", outs, Drain); end
    ncmp++;
    if (halt_out !== 1'b0) begin nfail++; $display("FAIL halt_early got=%b exp=0", halt_out); end
    step();
    ncmp++;
    if (halt_out !== 1'b1) begin nfail++; $display("FAIL halt_c3 got=%b exp=1", halt_out); end
    ncmp++;
    if (outs !== Halted) begin nfail++; $display("FAIL halt_outs got=%b exp=%b", outs, Halted); end
    step();
    ncmp++;
    if (halt_out !== 1'b1) begin nfail++; $display("FAIL halt_sticky got=%b exp=1", halt_out); end
    step();
    nRST = 1'b0;
    #1;
    ncmp++;
    if (outs !== Rst) begin nfail++; $display("FAIL halt_rst_outs got=%b exp=%b", outs, Rst); end
    step();
    ncmp++;
    if (halt_out !== 1'b0) begin nfail++; $display("FAIL halt_rst got=%b exp=0", halt_out); end
    nRST = 1'b1;
    idle();
    #1;
    ncmp++;
    if (outs !== Normal) begin nfail++; $display("FAIL halt_rst_run got=%b exp=%b", outs, Normal); end
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    test_reset();
    test_load_use();
    test_zero_filter();
    test_branch_load_use();
    test_memstall();
    test_ihit_counter();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
